spi_flash_responder: RTL and testbench

- Synthesizable SPI serial-flash emulator. Sits directly downstream of the JTAG-to-SPI bridge and plays the part of the flash: it takes MOSI, CSB and the SPI clock (DRCK1) as inputs and drives MISO back.
- Used for on-chip loopback checking of the bridge and of host flash-programming software without real flash.
- Oversamples the SPI lines on a free-running system clock, decodes a subset of flash commands in SPI mode 0, and serves reads and page programs from an internal byte array.

---
 rtl/spi_flash_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI serial-flash emulator: oversamples a mode-0 SPI bus on clk and answers
// RDID, RDSR, WREN, WRDI, READ and PP from an internal byte array.
module spi_flash_responder #(
    parameter int unsigned MEM_AW   = 10,
    parameter logic [23:0] JEDEC_ID = 24'h202016
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              csb,
    input  logic              mosi,
    output logic              miso,
    input  logic              mem_we,
    input  logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_wdata,
    output logic              cmd_strobe,
    output logic [7:0]        cmd_code,
    output logic              wel
);

    localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
    localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'(255);

    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;

    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DOUT, ST_DIN, ST_IGNORE} state_e;
    typedef enum logic [1:0] {SRC_ID, SRC_SR, SRC_MEM} src_e;

    logic [2:0]        sck_q;
    logic [2:0]        csb_q;
    logic [1:0]        mosi_q;
    state_e            state_q;
    src_e              src_q;
    logic [2:0]        bit_cnt_q;
    logic [6:0]        shift_q;
    logic [1:0]        id_idx_q;
    logic [1:0]        addr_cnt_q;
    logic [MEM_AW-1:0] addr_q;
    logic              pp_q;
    logic              miso_q;
    logic              cmd_strobe_q;
    logic [7:0]        cmd_code_q;
    logic              wel_q;
    logic [7:0]        rdata_q;
    logic [7:0]        mem_q [MEM_DEPTH];

    logic              csb_s_c;
    logic              csb_fall_c;
    logic              rise_c;
    logic              fall_c;
    logic              byte_done_c;
    logic [7:0]        byte_c;
    logic              din_we_c;
    logic [7:0]        page_lo_c;
    logic [MEM_AW-1:0] page_inc_c;
    logic [7:0]        src_byte_c;

    // Two-stage synchronisers plus one extra stage on sck/csb for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_q  <= 3'b000;
            csb_q  <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], sck};
            csb_q  <= {csb_q[1:0], csb};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    // Bus events and byte assembly helpers
    always_comb begin
        csb_s_c     = csb_q[1];
        csb_fall_c  = !csb_q[1] && csb_q[2];
        rise_c      = sck_q[1] && !sck_q[2] && !csb_s_c;
        fall_c      = !sck_q[1] && sck_q[2] && !csb_s_c;
        byte_done_c = rise_c && (bit_cnt_q == 3'd7);
        byte_c      = {shift_q, mosi_q[1]};
        din_we_c    = (state_q == ST_DIN) && byte_done_c;
        page_lo_c   = addr_q[7:0] + 8'd1;
        page_inc_c  = (addr_q & ~PAGE_MASK) | MEM_AW'(page_lo_c);
    end

    // Byte currently being shifted out on miso
    always_comb begin
        src_byte_c = 8'h00;
        case (src_q)
            SRC_ID: begin
                case (id_idx_q)
                    2'd0:    src_byte_c = JEDEC_ID[23:16];
                    2'd1:    src_byte_c = JEDEC_ID[15:8];
                    2'd2:    src_byte_c = JEDEC_ID[7:0];
                    default: src_byte_c = 8'h00;
                endcase
            end
            SRC_SR:  src_byte_c = {6'b000000, wel_q, 1'b0};
            SRC_MEM: src_byte_c = rdata_q;
            default: src_byte_c = 8'h00;
        endcase
    end

    // Command FSM, bit counter, address pointer and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            src_q        <= SRC_ID;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            id_idx_q     <= 2'd0;
            addr_cnt_q   <= 2'd0;
            addr_q       <= '0;
            pp_q         <= 1'b0;
            miso_q       <= 1'b0;
            cmd_strobe_q <= 1'b0;
            cmd_code_q   <= 8'h00;
            wel_q        <= 1'b0;
        end else begin
            cmd_strobe_q <= 1'b0;
            if (csb_s_c) begin
                state_q   <= ST_IDLE;
                bit_cnt_q <= 3'd0;
                miso_q    <= 1'b0;
                pp_q      <= 1'b0;
                if (pp_q) begin
                    wel_q <= 1'b0;
                end
            end else begin
                if (rise_c) begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    shift_q   <= byte_c[6:0];
                end
                // Bit index counts down as rises accumulate: after rise k, bit 7-k goes out
                if (fall_c) begin
                    miso_q <= (state_q == ST_DOUT) ? src_byte_c[~bit_cnt_q] : 1'b0;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (csb_fall_c) begin
                            state_q <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (byte_done_c) begin
                            cmd_code_q   <= byte_c;
                            cmd_strobe_q <= 1'b1;
                            addr_cnt_q   <= 2'd0;
                            case (byte_c)
                                OP_RDID: begin
                                    state_q  <= ST_DOUT;
                                    src_q    <= SRC_ID;
                                    id_idx_q <= 2'd0;
                                end
                                OP_RDSR: begin
                                    state_q <= ST_DOUT;
                                    src_q   <= SRC_SR;
                                end
                                OP_WREN: begin
                                    wel_q   <= 1'b1;
                                    state_q <= ST_IGNORE;
                                end
                                OP_WRDI: begin
                                    wel_q   <= 1'b0;
                                    state_q <= ST_IGNORE;
                                end
                                OP_READ: begin
                                    pp_q    <= 1'b0;
                                    state_q <= ST_ADDR;
                                end
                                OP_PP: begin
                                    pp_q    <= 1'b1;
                                    state_q <= wel_q ? ST_ADDR : ST_IGNORE;
                                end
                                default: state_q <= ST_IGNORE;
                            endcase
                        end
                    end
                    ST_ADDR: begin
                        if (byte_done_c) begin
                            addr_q     <= MEM_AW'({addr_q, byte_c});
                            addr_cnt_q <= addr_cnt_q + 2'd1;
                            if (addr_cnt_q == 2'd2) begin
                                state_q <= pp_q ? ST_DIN : ST_DOUT;
                                src_q   <= SRC_MEM;
                            end
                        end
                    end
                    ST_DOUT: begin
                        if (byte_done_c) begin
                            if (src_q == SRC_MEM) begin
                                addr_q <= addr_q + MEM_AW'(1);
                            end
                            if (id_idx_q != 2'd3) begin
                                id_idx_q <= id_idx_q + 2'd1;
                            end
                        end
                    end
                    ST_DIN: begin
                        if (byte_done_c) begin
                            addr_q <= page_inc_c;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Byte array: host port wins over page-program writes; read continuously prefetches mem[addr_q]
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end else if (din_we_c) begin
            mem_q[addr_q] <= byte_c;
        end
        rdata_q <= mem_q[addr_q];
    end

    assign miso       = miso_q;
    assign cmd_strobe = cmd_strobe_q;
    assign cmd_code   = cmd_code_q;
    assign wel        = wel_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: acts as a mode-0 SPI master and host preloader.
module tb_spi_flash_responder;

    localparam int unsigned MEM_AW = 10;
    localparam int unsigned HALF   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sck;
    logic              csb;
    logic              mosi;
    logic              miso;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cmd_strobe;
    logic [7:0]        cmd_code;
    logic              wel;

    int checks     = 0;
    int errors     = 0;
    int strobe_cnt = 0;
    int strobe_base;
    logic [7:0] rx;

    spi_flash_responder #(.MEM_AW(MEM_AW), .JEDEC_ID(24'h202016)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sck        (sck),
        .csb        (csb),
        .mosi       (mosi),
        .miso       (miso),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cmd_strobe (cmd_strobe),
        .cmd_code   (cmd_code),
        .wel        (wel)
    );

    always #5 clk = ~clk;

    // Count opcode strobes seen by the bus
    always @(posedge clk) begin
        if (cmd_strobe) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Shift nbits of tx MSB first; miso is sampled just before each rising edge
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rxd);
        rxd = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[3'(i)];
            wait_clk(HALF);
            rxd[3'(i)] = miso;
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] tx);
        logic [7:0] dummy;
        spi_xfer(tx, 8, dummy);
    endtask

    task automatic send_addr(input logic [23:0] a);
        send(a[23:16]);
        send(a[15:8]);
        send(a[7:0]);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        spi_xfer(8'h00, 8, got);
        check_eq(tag, 32'(got), 32'(exp));
    endtask

    task automatic cs_low();
        csb = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_high();
        wait_clk(HALF);
        csb = 1'b1;
        wait_clk(6);
    endtask

    task automatic host_write(input logic [MEM_AW-1:0] a, input logic [7:0] d);
        mem_addr  = a;
        mem_wdata = d;
        mem_we    = 1'b1;
        wait_clk(1);
        mem_we    = 1'b0;
    endtask

    task automatic one_byte_cmd(input logic [7:0] op);
        cs_low();
        send(op);
        cs_high();
    endtask

    task automatic read_one(input string tag, input logic [23:0] a, input logic [7:0] exp);
        cs_low();
        send(8'h03);
        send_addr(a);
        expect_byte(tag, exp);
        cs_high();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sck = 1'b0; csb = 1'b1; mosi = 1'b0;
        mem_we = 1'b0; mem_addr = '0; mem_wdata = 8'h00;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(2);
        check_eq("rst_miso", 32'(miso), 32'd0);
        check_eq("rst_strobe", 32'(cmd_strobe), 32'd0);
        check_eq("rst_cmd_code", 32'(cmd_code), 32'h00);
        check_eq("rst_wel", 32'(wel), 32'd0);

        // RDID
        strobe_base = strobe_cnt;
        cs_low();
        send(8'h9F);
        expect_byte("rdid_b0", 8'h20);
        expect_byte("rdid_b1", 8'h20);
        expect_byte("rdid_b2", 8'h16);
        expect_byte("rdid_b3", 8'h00);
        cs_high();
        check_eq("rdid_strobes", 32'(strobe_cnt - strobe_base), 32'd1);
        check_eq("rdid_code", 32'(cmd_code), 32'h9F);
        check_eq("idle_miso", 32'(miso), 32'd0);

        // Preload and READ across the array end
        host_write(10'h3FE, 8'hA5);
        host_write(10'h3FF, 8'h5A);
        host_write(10'h000, 8'hC3);
        host_write(10'h0FF, 8'h44);
        host_write(10'h100, 8'h66);
        cs_low();
        send(8'h03);
        send_addr(24'h0003FE);
        expect_byte("read_3fe", 8'hA5);
        expect_byte("read_3ff", 8'h5A);
        expect_byte("read_wrap", 8'hC3);
        cs_high();

        // PP without WREN is ignored
        cs_low();
        send(8'h02);
        send_addr(24'h0000FF);
        send(8'h77);
        cs_high();
        check_eq("pp_nowel_code", 32'(cmd_code), 32'h02);
        read_one("pp_nowel_ff", 24'h0000FF, 8'h44);

        // WREN, RDSR, PP with page wrap
        one_byte_cmd(8'h06);
        check_eq("wren_wel", 32'(wel), 32'd1);
        cs_low();
        send(8'h05);
        expect_byte("rdsr_wel1_a", 8'h02);
        expect_byte("rdsr_wel1_b", 8'h02);
        cs_high();
        cs_low();
        send(8'h02);
        send_addr(24'h0000FF);
        send(8'h11);
        send(8'h22);
        cs_high();
        check_eq("pp_wel_cleared", 32'(wel), 32'd0);
        cs_low();
        send(8'h05);
        expect_byte("rdsr_wel0", 8'h00);
        cs_high();
        cs_low();
        send(8'h03);
        send_addr(24'h0000FF);
        expect_byte("pp_data_ff", 8'h11);
        expect_byte("pp_upper_held", 8'h66);
        cs_high();
        read_one("pp_page_wrap", 24'h000000, 8'h22);

        // Partial PP data byte must not be written
        host_write(10'h010, 8'h5C);
        one_byte_cmd(8'h06);
        cs_low();
        send(8'h02);
        send_addr(24'h000010);
        spi_xfer(8'hFF, 5, rx);
        cs_high();
        check_eq("abort_wel", 32'(wel), 32'd0);
        read_one("abort_nowrite", 24'h000010, 8'h5C);
        check_eq("abort_next_code", 32'(cmd_code), 32'h03);

        // WRDI clears the latch
        one_byte_cmd(8'h06);
        one_byte_cmd(8'h04);
        check_eq("wrdi_wel", 32'(wel), 32'd0);
        check_eq("wrdi_code", 32'(cmd_code), 32'h04);

        // Unknown opcode keeps miso low
        cs_low();
        send(8'hAB);
        expect_byte("unk_miso_a", 8'h00);
        expect_byte("unk_miso_b", 8'h00);
        cs_high();
        check_eq("unk_code", 32'(cmd_code), 32'hAB);
        cs_low();
        send(8'h9F);
        expect_byte("rdid2_b0", 8'h20);
        expect_byte("rdid2_b1", 8'h20);
        expect_byte("rdid2_b2", 8'h16);
        cs_high();

        // Reset in the middle of a READ
        one_byte_cmd(8'h06);
        cs_low();
        send(8'h03);
        send_addr(24'h0003FE);
        expect_byte("rstmid_first", 8'hA5);
        spi_xfer(8'h00, 3, rx);
        wait_clk(3);
        check_eq("rstmid_miso_before", 32'(miso), 32'd1);
        rst_n = 1'b0;
        wait_clk(2);
        check_eq("rstmid_miso", 32'(miso), 32'd0);
        check_eq("rstmid_wel", 32'(wel), 32'd0);
        check_eq("rstmid_code", 32'(cmd_code), 32'h00);
        rst_n = 1'b1;
        cs_high();
        cs_low();
        send(8'h03);
        send_addr(24'h0003FF);
        expect_byte("post_rst_a", 8'h5A);
        expect_byte("post_rst_b", 8'h22);
        cs_high();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
